// File: rtl/memory_bist.sv
// -----------------------------------------------------------------------------
// memory_bist
//   March-style BIST controller for a single-port synchronous SRAM.
//   Runs four back-to-back passes over the whole array: write pat, read pat,
//   write ~pat, read ~pat. The read data is compared two edges after the read
//   is driven, through a small valid/expected pipeline that runs regardless of
//   the FSM state, so the last read of a pass is still checked while the FSM
//   sits in DRAIN.
//
// Ports
//   CLK, RSTN          clock, async active-low reset
//   START              run request (only honoured in IDLE or DONE)
//   MODE[1:0]          pattern select, latched when a run starts
//   STOP_ON_FAIL       abort on first mismatch, latched when a run starts
//   BUSY, DONE         run in progress / run finished (DONE held)
//   FAIL               sticky mismatch flag
//   FAIL_ADDR/DATA     address and read data of the first mismatch
//   ERR_CNT[7:0]       saturating mismatch count
//   MEM_CEN, MEM_WEN   active-low SRAM chip/write enable (registered)
//   MEM_A, MEM_D       SRAM address / write data (registered)
//   MEM_Q              SRAM read data, valid after the sampling edge
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | after reset, waiting for START
// WR0    | writing pat(a), a = 0..DEPTH-1
// RD0    | reading, expecting pat(a)
// WR1    | writing ~pat(a)
// RD1    | reading, expecting ~pat(a)
// DRAIN  | SRAM idle, last read compare still in flight
// DONE   | run finished, results held until START or reset
// -----------------------------------------------------------------------------
module memory_bist #(
    parameter int AW = 7,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic [1:0]    MODE,
    input  logic          STOP_ON_FAIL,
    output logic          BUSY,
    output logic          DONE,
    output logic          FAIL,
    output logic [AW-1:0] FAIL_ADDR,
    output logic [DW-1:0] FAIL_DATA,
    output logic [7:0]    ERR_CNT,
    output logic          MEM_CEN,
    output logic          MEM_WEN,
    output logic [AW-1:0] MEM_A,
    output logic [DW-1:0] MEM_D,
    input  logic [DW-1:0] MEM_Q
);

    localparam int LW = $clog2(DW);

    typedef enum logic [2:0] {
        S_IDLE, S_WR0, S_RD0, S_WR1, S_RD1, S_DRAIN, S_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [1:0]    mode_q;
    logic          stop_q;

    // read pipeline: s1 = read driven on MEM_*, s2 = read sampled by SRAM
    logic          s1_valid;
    logic [DW-1:0] s1_exp;
    logic          s2_valid;
    logic [DW-1:0] s2_exp;
    logic [AW-1:0] s2_addr;

    state_t        op_state;
    logic [AW-1:0] op_addr;
    logic          op_read;
    logic [DW-1:0] op_data;
    logic          last_addr;
    logic          mismatch;
    logic          start_ok;

    function automatic logic [DW-1:0] pat_f(input logic [AW-1:0] a, input logic [1:0] m);
        logic [63:0]   ext;
        logic [DW-1:0] p;
        ext = 64'(a);
        case (m)
            2'b00:   p = ext[DW-1:0];
            2'b01:   p = {(DW/2){2'b01}} ^ {DW{a[0]}};
            2'b10:   p = '0;
            default: p = DW'(1) << ext[LW-1:0];
        endcase
        return p;
    endfunction

    // next operation to drive while a pass is running
    always_comb begin
        last_addr = (addr == '1);
        op_state  = state;
        op_addr   = addr + AW'(1);
        if (last_addr) begin
            op_addr = '0;
            case (state)
                S_WR0:   op_state = S_RD0;
                S_RD0:   op_state = S_WR1;
                S_WR1:   op_state = S_RD1;
                default: op_state = state;
            endcase
        end
        op_read = (op_state == S_RD0) || (op_state == S_RD1);
        op_data = pat_f(op_addr, mode_q);
        if ((op_state == S_WR1) || (op_state == S_RD1))
            op_data = ~op_data;
        mismatch = s2_valid && (MEM_Q != s2_exp);
        start_ok = START && ((state == S_IDLE) || (state == S_DONE));
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_IDLE;
            addr      <= '0;
            mode_q    <= 2'b00;
            stop_q    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_exp    <= '0;
            s2_valid  <= 1'b0;
            s2_exp    <= '0;
            s2_addr   <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_DATA <= '0;
            ERR_CNT   <= 8'd0;
            MEM_CEN   <= 1'b1;
            MEM_WEN   <= 1'b1;
            MEM_A     <= '0;
            MEM_D     <= '0;
        end else if (start_ok) begin
            state     <= S_WR0;
            addr      <= '0;
            mode_q    <= MODE;
            stop_q    <= STOP_ON_FAIL;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_DATA <= '0;
            ERR_CNT   <= 8'd0;
            MEM_CEN   <= 1'b0;
            MEM_WEN   <= 1'b0;
            MEM_A     <= '0;
            MEM_D     <= pat_f('0, MODE);
        end else begin
            s1_valid <= 1'b0;
            s2_valid <= s1_valid;
            s2_exp   <= s1_exp;
            s2_addr  <= MEM_A;

            if (mismatch) begin
                FAIL <= 1'b1;
                if (ERR_CNT != 8'hFF)
                    ERR_CNT <= ERR_CNT + 8'd1;
                if (!FAIL) begin
                    FAIL_ADDR <= s2_addr;
                    FAIL_DATA <= MEM_Q;
                end
            end

            if (mismatch && stop_q) begin
                // abort: the op already on the bus is the only one that follows
                state    <= S_DONE;
                BUSY     <= 1'b0;
                DONE     <= 1'b1;
                MEM_CEN  <= 1'b1;
                MEM_WEN  <= 1'b1;
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                case (state)
                    S_WR0, S_RD0, S_WR1, S_RD1: begin
                        if ((state == S_RD1) && last_addr) begin
                            state   <= S_DRAIN;
                            MEM_CEN <= 1'b1;
                            MEM_WEN <= 1'b1;
                        end else begin
                            state    <= op_state;
                            addr     <= op_addr;
                            MEM_CEN  <= 1'b0;
                            MEM_WEN  <= op_read;
                            MEM_A    <= op_addr;
                            MEM_D    <= op_data;
                            s1_valid <= op_read;
                            s1_exp   <= op_data;
                        end
                    end
                    S_DRAIN: begin
                        state <= S_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule
